// File: rtl/dac_write_arbiter_if.sv
// Requester and DAC-transmitter signals seen by dac_write_arbiter.
// slave = arbiter view, master = environment (requesters + transmitter) view.
interface dac_write_arbiter_if;
  logic        req0;
  logic        req1;
  logic [11:0] data0;
  logic [11:0] data1;
  logic [1:0]  pd0;
  logic [1:0]  pd1;
  logic        ack0;
  logic        ack1;
  logic        err0;
  logic        err1;
  logic        tx_start;
  logic [11:0] tx_data;
  logic [1:0]  tx_pd;
  logic        tx_busy;
  logic        tx_done;
  logic        tx_nack;
  logic        busy;
  logic [1:0]  grant;
  logic [7:0]  err_count;

  modport slave (
    input  req0, req1, data0, data1, pd0, pd1, tx_busy, tx_done, tx_nack,
    output ack0, ack1, err0, err1, tx_start, tx_data, tx_pd, busy, grant, err_count
  );

  modport master (
    output req0, req1, data0, data1, pd0, pd1, tx_busy, tx_done, tx_nack,
    input  ack0, ack1, err0, err1, tx_start, tx_data, tx_pd, busy, grant, err_count
  );
endinterface

// File: rtl/dac_write_arbiter.sv
// Round-robin arbiter for two DAC writers feeding one I2C transmitter, with NACK retry and timeout.
// Latency: req -> tx_start 2 cycles, tx_done -> ack/err 1 cycle; tx_busy holds off the launch.
module dac_write_arbiter #(
  parameter int MAX_RETRY   = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic               clk,
  input  logic               rst,
  dac_write_arbiter_if.slave bus
);

  localparam int RTW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int TOW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, RESP} state_t;

  state_t          state_q, state_d;
  logic [1:0]      grant_q, grant_d;
  logic [11:0]     data_q, data_d;
  logic [1:0]      pd_q, pd_d;
  logic [RTW-1:0]  retry_q, retry_d;
  logic [TOW-1:0]  tmo_q, tmo_d;
  logic            fail_q, fail_d;
  logic            rr_q, rr_d;
  logic [7:0]      errcnt_q, errcnt_d;
  logic            start_q, start_d;
  logic            pick1;
  logic            ack0, ack1, err0, err1, busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= 2'b00;
      data_q   <= 12'h000;
      pd_q     <= 2'b00;
      retry_q  <= '0;
      tmo_q    <= '0;
      fail_q   <= 1'b0;
      rr_q     <= 1'b0;
      errcnt_q <= 8'h00;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      data_q   <= data_d;
      pd_q     <= pd_d;
      retry_q  <= retry_d;
      tmo_q    <= tmo_d;
      fail_q   <= fail_d;
      rr_q     <= rr_d;
      errcnt_q <= errcnt_d;
      start_q  <= start_d;
    end
  end

  // rr_q set means requester 1 wins a tie.
  assign pick1 = bus.req1 & (~bus.req0 | rr_q);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    data_d   = data_q;
    pd_d     = pd_q;
    retry_d  = retry_q;
    tmo_d    = tmo_q;
    fail_d   = fail_q;
    rr_d     = rr_q;
    errcnt_d = errcnt_q;
    start_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req0 | bus.req1) begin
          grant_d = pick1 ? 2'b10 : 2'b01;
          data_d  = pick1 ? bus.data1 : bus.data0;
          pd_d    = pick1 ? bus.pd1 : bus.pd0;
          retry_d = '0;
          fail_d  = 1'b0;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        if (!bus.tx_busy) begin
          start_d = 1'b1;
          tmo_d   = '0;
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        tmo_d = tmo_q + 1'b1;
        // A completing frame wins over a timeout expiring in the same cycle.
        if (bus.tx_done) begin
          if (!bus.tx_nack) begin
            fail_d  = 1'b0;
            state_d = RESP;
          end else if (retry_q < RTW'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            state_d = LAUNCH;
          end else begin
            fail_d  = 1'b1;
            state_d = RESP;
          end
        end else if (tmo_q == TOW'(TIMEOUT_CYC - 1)) begin
          fail_d  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        rr_d    = grant_q[0];
        grant_d = 2'b00;
        if (fail_q && (errcnt_q != 8'hFF)) begin
          errcnt_d = errcnt_q + 8'd1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ack0 = 1'b0;
    ack1 = 1'b0;
    err0 = 1'b0;
    err1 = 1'b0;
    busy = (state_q != IDLE);
    if (state_q == RESP) begin
      ack0 = grant_q[0] & ~fail_q;
      ack1 = grant_q[1] & ~fail_q;
      err0 = grant_q[0] & fail_q;
      err1 = grant_q[1] & fail_q;
    end
  end

  assign bus.ack0      = ack0;
  assign bus.ack1      = ack1;
  assign bus.err0      = err0;
  assign bus.err1      = err1;
  assign bus.busy      = busy;
  assign bus.tx_start  = start_q;
  assign bus.tx_data   = data_q;
  assign bus.tx_pd     = pd_q;
  assign bus.grant     = grant_q;
  assign bus.err_count = errcnt_q;

endmodule

// File: tb/tb_dac_write_arbiter.sv
// Scoreboard bench for dac_write_arbiter: expected transactions are queued at stimulus time
// and retired against tx_start and ack/err pulses observed on the falling clock edge.
module tb_dac_write_arbiter;

  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  dac_write_arbiter_if bus ();

  dac_write_arbiter #(.MAX_RETRY(2), .TIMEOUT_CYC(TMO)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        owner;
    logic [11:0] data;
    logic [1:0]  pd;
    logic        is_err;
    int          starts;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   starts_seen = 0;
  int   n, m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic owner, input logic [11:0] data, input logic [1:0] pd,
                          input logic is_err, input int starts);
    exp_t x;
    x.owner  = owner;
    x.data   = data;
    x.pd     = pd;
    x.is_err = is_err;
    x.starts = starts;
    exp_q.push_back(x);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      starts_seen = 0;
    end else begin
      if (bus.tx_start) begin
        starts_seen++;
        if (exp_q.size() == 0) begin
          chk("unexpected_start", 32'd1, 32'd0);
        end else begin
          chk("start_data", 32'(bus.tx_data), 32'(exp_q[0].data));
          chk("start_pd", 32'(bus.tx_pd), 32'(exp_q[0].pd));
          chk("start_grant", 32'(bus.grant), exp_q[0].owner ? 32'd2 : 32'd1);
        end
      end
      if (bus.ack0 | bus.ack1 | bus.err0 | bus.err1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", 32'({bus.ack1, bus.ack0, bus.err1, bus.err0}), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("resp_onehot", 32'($countones({bus.ack1, bus.ack0, bus.err1, bus.err0})), 32'd1);
          chk("resp_owner", 32'(bus.ack1 | bus.err1), 32'(e.owner));
          chk("resp_kind", 32'(bus.err0 | bus.err1), 32'(e.is_err));
          chk("resp_starts", 32'(starts_seen), 32'(e.starts));
          chk("resp_data", 32'(bus.tx_data), 32'(e.data));
        end
        starts_seen = 0;
      end
    end
  end

  task automatic apply_reset();
    rst = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // n = number of falling edges after the current cycle's one until tx_start is seen.
  task automatic wait_start(input int budget, output int cyc);
    cyc = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (bus.tx_start) begin
        cyc = k;
        break;
      end
    end
    if (cyc < 0) chk("start_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_resp(input int budget, output int cyc);
    cyc = -1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (bus.ack0 | bus.ack1 | bus.err0 | bus.err1) begin
        cyc = k;
        break;
      end
    end
    if (cyc < 0) chk("resp_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int hit;
    hit = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!bus.busy) begin
        hit = 1;
        break;
      end
    end
    if (hit == 0) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic respond(input int d, input logic nack);
    repeat (d) @(posedge clk);
    #1;
    bus.tx_done = 1'b1;
    bus.tx_nack = nack;
    @(posedge clk);
    #1;
    bus.tx_done = 1'b0;
    bus.tx_nack = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_grant"}, 32'(bus.grant), 32'd0);
    chk({tag, "_tx_start"}, 32'(bus.tx_start), 32'd0);
    chk({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
    chk({tag, "_tx_pd"}, 32'(bus.tx_pd), 32'd0);
    chk({tag, "_err_count"}, 32'(bus.err_count), 32'd0);
    chk({tag, "_pulses"}, 32'({bus.ack0, bus.ack1, bus.err0, bus.err1}), 32'd0);
  endtask

  initial begin
    bus.req0 = 1'b0;  bus.req1 = 1'b0;
    bus.data0 = '0;   bus.data1 = '0;
    bus.pd0 = '0;     bus.pd1 = '0;
    bus.tx_busy = 1'b0; bus.tx_done = 1'b0; bus.tx_nack = 1'b0;
    rst = 1'b1;
    #2;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single write; data0 changes after grant and must not leak into the transaction.
    bus.req0 = 1'b1; bus.data0 = 12'h064; bus.pd0 = 2'd0;
    push_exp(1'b0, 12'h064, 2'd0, 1'b0, 1);
    wait_start(10, n);
    chk("single_start_lat", 32'(n), 32'd2);
    bus.req0 = 1'b0; bus.data0 = 12'hABC; bus.pd0 = 2'd3;
    fork
      respond(10, 1'b0);
      wait_resp(20, m);
    join
    chk("single_ack_lat", 32'(m), 32'd11);
    wait_idle(5);
    chk("single_err_count", 32'(bus.err_count), 32'd0);

    // tx_done on the last timeout cycle wins.
    apply_reset();
    bus.req0 = 1'b1; bus.data0 = 12'h7E1; bus.pd0 = 2'd2;
    push_exp(1'b0, 12'h7E1, 2'd2, 1'b0, 1);
    wait_start(10, n);
    bus.req0 = 1'b0;
    fork
      respond(TMO - 1, 1'b0);
      wait_resp(TMO + 10, m);
    join
    chk("prec_ack_lat", 32'(m), 32'(TMO));
    wait_idle(5);
    chk("prec_err_count", 32'(bus.err_count), 32'd0);

    // Transmitter busy for 10 cycles at launch.
    apply_reset();
    bus.tx_busy = 1'b1;
    bus.req1 = 1'b1; bus.data1 = 12'h3C3; bus.pd1 = 2'd1;
    push_exp(1'b1, 12'h3C3, 2'd1, 1'b0, 1);
    fork
      wait_start(40, n);
      begin
        repeat (10) @(posedge clk);
        #1 bus.tx_busy = 1'b0;
      end
    join
    chk("busy_start_lat", 32'(n), 32'd11);
    bus.req1 = 1'b0;
    fork
      respond(2, 1'b0);
      wait_resp(10, m);
    join
    chk("busy_ack_lat", 32'(m), 32'd3);
    wait_idle(5);

    // Every frame NACKed: initial launch plus two retries, then err.
    apply_reset();
    bus.req1 = 1'b1; bus.data1 = 12'h5A5; bus.pd1 = 2'd2;
    push_exp(1'b1, 12'h5A5, 2'd2, 1'b1, 3);
    for (int i = 0; i < 3; i++) begin
      wait_start(20, n);
      if (i == 0) bus.req1 = 1'b0;
      respond(4, 1'b1);
    end
    wait_resp(10, m);
    wait_idle(5);
    chk("nack_err_count", 32'(bus.err_count), 32'd1);
    repeat (6) @(negedge clk);
    chk("nack_no_extra_start", 32'(starts_seen), 32'd0);

    // Both requesters held high: strict alternation starting with 0.
    apply_reset();
    bus.req0 = 1'b1; bus.data0 = 12'h111; bus.pd0 = 2'd1;
    bus.req1 = 1'b1; bus.data1 = 12'h222; bus.pd1 = 2'd3;
    push_exp(1'b0, 12'h111, 2'd1, 1'b0, 1);
    push_exp(1'b1, 12'h222, 2'd3, 1'b0, 1);
    push_exp(1'b0, 12'h111, 2'd1, 1'b0, 1);
    push_exp(1'b1, 12'h222, 2'd3, 1'b0, 1);
    for (int i = 0; i < 4; i++) begin
      wait_start(20, n);
      if (i == 3) begin
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
      end
      respond(3, 1'b0);
    end
    wait_idle(10);
    repeat (5) @(negedge clk);
    chk("rr_no_extra_start", 32'(starts_seen), 32'd0);
    chk("rr_queue_drained", 32'(exp_q.size()), 32'd0);

    // No tx_done at all: timeout, never retried.
    apply_reset();
    bus.req0 = 1'b1; bus.data0 = 12'h0F0; bus.pd0 = 2'd1;
    push_exp(1'b0, 12'h0F0, 2'd1, 1'b1, 1);
    wait_start(10, n);
    bus.req0 = 1'b0;
    wait_resp(TMO + 10, m);
    chk("tmo_err_lat", 32'(m), 32'(TMO));
    wait_idle(5);
    chk("tmo_err_count", 32'(bus.err_count), 32'd1);
    repeat (5) @(negedge clk);
    chk("tmo_no_retry", 32'(starts_seen), 32'd0);

    // Reset mid-WAIT_DONE with requester 1 owning; pointer currently favours 1.
    bus.req1 = 1'b1; bus.data1 = 12'hFFF; bus.pd1 = 2'd3;
    push_exp(1'b1, 12'hFFF, 2'd3, 1'b0, 1);
    wait_start(10, n);
    bus.req1 = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    bus.req0 = 1'b1; bus.data0 = 12'h246; bus.pd0 = 2'd0;
    bus.req1 = 1'b1; bus.data1 = 12'h135; bus.pd1 = 2'd1;
    push_exp(1'b0, 12'h246, 2'd0, 1'b0, 1);
    push_exp(1'b1, 12'h135, 2'd1, 1'b0, 1);
    for (int i = 0; i < 2; i++) begin
      wait_start(20, n);
      if (i == 1) begin
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
      end
      respond(3, 1'b0);
    end
    wait_idle(10);
    chk("midrst_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("midrst_err_count", 32'(bus.err_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
